bcd_display_ctrl: RTL and testbench
===================================

Name: bcd_display_ctrl

Overview:
- Parametrised successor to the fixed 13-bit, 4-digit BCD display path: converts a WIDTH-bit binary value, unsigned or two's-complement signed, to decimal with a sequential double-dabble FSM.
- Drives an NUM_DIGITS multiplexed seven-segment display with leading-zero blanking, a minus sign and overflow indication.
- Sits between the ALU result bus and the board anode/segment pins.

Parameters:
- WIDTH, 16, input value width; valid range 4..32.
- NUM_DIGITS, 4, number of physical display digits; valid range 1..8.
- REFRESH_DIV, 100000, clock cycles per digit dwell; minimum 2.
- BLANK_ZEROS, 1, 1 blanks leading zeros; 0 shows all digits.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- number  input  WIDTH  value to display.
- signed_mode  input  1  1 means number is two's-complement.
- anode  output  NUM_DIGITS  digit enables, active-low; bit 0 is the rightmost digit.
- seg  output  7  segments, active-low; seg[0]=a .. seg[6]=g.
- busy  output  1  high while a conversion is in progress.
- overflow  output  1  high while the displayed value does not fit.

Behaviour:
- Reset values: anode all 1; seg 7'h7F; busy 0; overflow 0; digit index 0; refresh counter 0; display register all-blank; FSM in IDLE.
- Clock and reset: one clock (clk). reset is asynchronous and active-high; it aborts any conversion in progress.
- Internal BCD width: BCD_DIGITS = (WIDTH*3)/10 + 1, held as a localparam.
- FSM IDLE:
  - Each cycle, sample number and signed_mode.
  - neg = signed_mode & number[WIDTH-1].
  - mag = neg ? (two's complement of number) : number, computed in WIDTH+1 bits so the most-negative value gives 2^(WIDTH-1).
  - Clear the BCD accumulator; go to SHIFT; busy=1.
- FSM SHIFT:
  - Run exactly WIDTH iterations, one per cycle.
  - In each iteration, add 3 to every BCD nibble >=5, then shift {bcd, mag} left by 1.
  - After the last iteration, go to DONE.
- FSM DONE (one cycle):
  - avail = NUM_DIGITS - neg.
  - overflow = any BCD nibble at index >= avail is nonzero, or avail==0.
  - Commit digits, neg and overflow to the display register atomically; go to IDLE.
  - busy=0 in DONE.
- Latency: WIDTH+2 cycles from the IDLE sample to display update.
- Conversion restarts continuously. number changing mid-conversion has no effect until the next IDLE sample.
- The display never shows partial results.
- Refresh counter:
  - Counts 0..REFRESH_DIV-1.
  - On wrap, the digit index increments modulo NUM_DIGITS.
  - anode = ~(1<<index), one-hot low.
- Digit content:
  - If overflow: every digit shows '-' (only g lit, seg=7'b0111111).
  - Otherwise, for digit i:
    - Numeral i is shown if i==0, or BLANK_ZEROS==0, or any digit >= i is nonzero.
    - Minus sign: if neg, the digit immediately left of the highest shown numeral shows '-'. When BLANK_ZEROS==0, the minus sign is at digit NUM_DIGITS-1.
    - All remaining digits are blank (7'h7F).
- Numeral encodings (active-low, g..a):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001.
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- Value zero in signed mode is not negative; it shows a single '0'.

Decomposition:
- Shared package display_pkg:
  - seven-segment encoding constants: SEG_BLANK, SEG_MINUS, SEG_DIGIT[0:9].
  - FSM state typedef with states IDLE, SHIFT, DONE.
  - the BCD_DIGITS width function.
- Natural sub-module: bin2bcd_seq, holding the IDLE/SHIFT/DONE converter with outputs bcd, neg, overflow and a done strobe.
- The top of the block holds the refresh counter, blanking logic and segment mux.

Test Plan (REFRESH_DIV=4 for simulation):
- WIDTH=13, unsigned, number=1234 -> done after 15 cycles; over one scan, anode[0..3] low in turn with seg = '4','3','2','1'; overflow=0.
- WIDTH=16, signed_mode=1, number=16'hFFD6 (-42) -> digits 3..0 show blank, '-', '4', '2'.
- WIDTH=16, unsigned, number=10000 -> all four digits '-', overflow=1. Then number=9999 -> '9999', overflow=0 after the next DONE.
- number=0 with BLANK_ZEROS=1 -> digit0 shows '0', digits 1..3 blank. The same input with BLANK_ZEROS=0 -> '0000'.
- Signed -1000 with NUM_DIGITS=4 -> overflow=1, because the minus sign leaves only 3 digits. The most-negative value 16'h8000 -> overflow=1, and the converter does not hang.
- Assert reset mid-SHIFT and mid-scan -> outputs return to reset values within the same cycle; after release, the first valid display appears WIDTH+2 cycles later.

Source files
------------

// File: rtl/display_pkg.sv
// Shared constants, FSM state type and sizing helpers for the BCD display path.
// Segment codes are active-low, bit order g..a.
package display_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    function automatic int bcd_digits(input int width);
        return (width * 3) / 10 + 1;
    endfunction

    function automatic logic [6:0] digit_seg(input logic [3:0] d);
        logic [6:0] s;
        s = SEG_BLANK;
        if (d <= 4'd9) s = SEG_DIGIT[d];
        return s;
    endfunction

endpackage

// File: rtl/bcd_display_ctrl_bin2bcd.sv
// Sequential double-dabble converter: samples in IDLE, WIDTH shift cycles,
// then a one-cycle DONE strobe while bcd/neg/overflow are stable.
module bin2bcd_seq
    import display_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int NUM_DIGITS = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [WIDTH-1:0]             number,
    input  logic                         signed_mode,
    output logic [4*bcd_digits(WIDTH)-1:0] bcd,
    output logic                         neg,
    output logic                         overflow,
    output logic                         busy,
    output logic                         done
);

    localparam int BCD_DIGITS = bcd_digits(WIDTH);
    localparam int CW         = $clog2(WIDTH + 1);

    state_t                  state;
    state_t                  state_next;
    logic [WIDTH-1:0]        mag;
    logic [CW-1:0]           iter;
    logic [4*BCD_DIGITS-1:0] adj;
    logic                    sample_neg;
    int                      avail;

    assign sample_neg = signed_mode & number[WIDTH-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: state_next = SHIFT;
            SHIFT: begin
                busy = 1'b1;
                if (iter == CW'(WIDTH - 1)) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        adj = bcd;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    // Minus sign steals the leftmost digit from the numeral field.
    always_comb begin
        avail    = NUM_DIGITS - (neg ? 1 : 0);
        overflow = (avail == 0);
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (i >= avail && bcd[4*i +: 4] != 4'd0) overflow = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mag  <= '0;
            bcd  <= '0;
            iter <= '0;
            neg  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    neg  <= sample_neg;
                    mag  <= sample_neg ? (~number + WIDTH'(1)) : number;
                    bcd  <= '0;
                    iter <= '0;
                end
                SHIFT: begin
                    {bcd, mag} <= {adj[4*BCD_DIGITS-2:0], mag, 1'b0};
                    iter       <= iter + CW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/bcd_display_ctrl.sv
// Binary-to-decimal multiplexed seven-segment driver with leading-zero
// blanking, minus sign and overflow dashes.
module bcd_display_ctrl
    import display_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_ZEROS = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      number,
    input  logic                  signed_mode,
    output logic [NUM_DIGITS-1:0] anode,
    output logic [6:0]            seg,
    output logic                  busy,
    output logic                  overflow
);

    localparam int BCD_DIGITS = bcd_digits(WIDTH);
    localparam int DW         = 4 * NUM_DIGITS;
    localparam int CW         = $clog2(REFRESH_DIV);
    localparam int IW         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [4*BCD_DIGITS-1:0] conv_bcd;
    logic                    conv_neg;
    logic                    conv_ovf;
    logic                    conv_done;

    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;
    logic          running;
    logic [DW-1:0] disp_digits;
    logic          disp_neg;
    logic          disp_ovf;
    logic          disp_valid;
    logic [3:0]    cur;
    int            msd;
    int            minus_pos;

    bin2bcd_seq #(
        .WIDTH      (WIDTH),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_conv (
        .clk         (clk),
        .reset       (reset),
        .number      (number),
        .signed_mode (signed_mode),
        .bcd         (conv_bcd),
        .neg         (conv_neg),
        .overflow    (conv_ovf),
        .busy        (busy),
        .done        (conv_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt         <= '0;
            idx         <= '0;
            running     <= 1'b0;
            disp_digits <= '0;
            disp_neg    <= 1'b0;
            disp_ovf    <= 1'b0;
            disp_valid  <= 1'b0;
        end else begin
            running <= 1'b1;
            if (cnt == CW'(REFRESH_DIV - 1)) begin
                cnt <= '0;
                idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + IW'(1);
            end else begin
                cnt <= cnt + CW'(1);
            end
            // Whole result lands in one edge so no partial value is ever shown.
            if (conv_done) begin
                disp_digits <= DW'(conv_bcd);
                disp_neg    <= conv_neg;
                disp_ovf    <= conv_ovf;
                disp_valid  <= 1'b1;
            end
        end
    end

    assign overflow = disp_ovf;
    assign anode    = running ? ~(NUM_DIGITS'(1) << idx) : '1;

    always_comb begin
        msd = 0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (disp_digits[4*i +: 4] != 4'd0) msd = i;
        end
        minus_pos = (BLANK_ZEROS != 0) ? msd + 1 : NUM_DIGITS - 1;
        cur       = disp_digits[4*idx +: 4];
        seg       = SEG_BLANK;
        if (!disp_valid)
            seg = SEG_BLANK;
        else if (disp_ovf)
            seg = SEG_MINUS;
        else if (disp_neg && int'(idx) == minus_pos)
            seg = SEG_MINUS;
        else if (BLANK_ZEROS == 0 || int'(idx) <= msd)
            seg = digit_seg(cur);
    end

endmodule

// File: tb/tb_bcd_display_ctrl.sv
// Bench for bcd_display_ctrl: 16-bit blanking instance and 13-bit
// all-digits instance, table vectors, random values and reset/latency.
module tb_bcd_display_ctrl;

    localparam logic [6:0] SB = 7'h7F;
    localparam logic [6:0] SM = 7'b0111111;
    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S6 = 7'b0000010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam int RDIV   = 4;
    localparam int SETTLE = 40;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] num0 = '0;
    logic        sm0 = 1'b0;
    logic [3:0]  anode0;
    logic [6:0]  seg0;
    logic        busy0;
    logic        ovf0;
    logic [12:0] num1 = '0;
    logic        sm1 = 1'b0;
    logic [3:0]  anode1;
    logic [6:0]  seg1;
    logic        busy1;
    logic        ovf1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bcd_display_ctrl #(
        .WIDTH(16), .NUM_DIGITS(4), .REFRESH_DIV(RDIV), .BLANK_ZEROS(1)
    ) dut0 (
        .clk(clk), .reset(reset), .number(num0), .signed_mode(sm0),
        .anode(anode0), .seg(seg0), .busy(busy0), .overflow(ovf0)
    );

    bcd_display_ctrl #(
        .WIDTH(13), .NUM_DIGITS(4), .REFRESH_DIV(RDIV), .BLANK_ZEROS(0)
    ) dut1 (
        .clk(clk), .reset(reset), .number(num1), .signed_mode(sm1),
        .anode(anode1), .seg(seg1), .busy(busy1), .overflow(ovf1)
    );

    typedef struct {
        logic [15:0] num;
        bit          sm;
        logic [27:0] exp;
        logic        ovf;
    } vec_t;

    vec_t tab0[$];
    vec_t tab1[$];

    function automatic logic [6:0] enc(input longint d);
        case (d)
            0: return S0;
            1: return S1;
            2: return S2;
            3: return S3;
            4: return S4;
            5: return S5;
            6: return S6;
            7: return S7;
            8: return S8;
            default: return S9;
        endcase
    endfunction

    // Decimal-string view of the value: length plus sign must fit in 4 places.
    function automatic void model(input longint bits, input int width,
                                  input bit sm, input bit bz,
                                  output logic [27:0] exp, output logic ovf);
        longint mag;
        longint t;
        bit     neg;
        int     len;
        logic [6:0] s;
        neg = sm && (((bits >> (width - 1)) & 1) != 0);
        mag = neg ? ((longint'(1) << width) - bits) : bits;
        len = 1;
        t = mag;
        while (t >= 10) begin
            t = t / 10;
            len++;
        end
        ovf = (len + int'(neg)) > 4;
        t = mag;
        for (int i = 0; i < 4; i++) begin
            if (ovf) s = SM;
            else if (i < len) s = enc(t % 10);
            else if (!bz) s = (neg && i == 3) ? SM : S0;
            else s = (neg && i == len) ? SM : SB;
            exp[7*i +: 7] = s;
            t = t / 10;
        end
    endfunction

    function automatic logic [3:0] cur_anode(input bit w);
        return w ? anode1 : anode0;
    endfunction

    function automatic logic [6:0] cur_seg(input bit w);
        return w ? seg1 : seg0;
    endfunction

    function automatic logic cur_ovf(input bit w);
        return w ? ovf1 : ovf0;
    endfunction

    task automatic check(input bit ok, input string name,
                         input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic check_disp(input bit w, input logic [27:0] exp,
                              input logic eovf, input string name);
        logic [3:0] want;
        int n;
        for (int d = 0; d < 4; d++) begin
            want = ~(4'b0001 << d);
            n = 0;
            while (cur_anode(w) !== want && n < 64) begin
                @(negedge clk);
                n++;
            end
            if (n >= 64)
                check(1'b0, $sformatf("%s anode%0d timeout", name, d),
                      32'(cur_anode(w)), 32'(want));
            else
                check(cur_seg(w) === exp[7*d +: 7],
                      $sformatf("%s seg%0d", name, d),
                      32'(cur_seg(w)), 32'(exp[7*d +: 7]));
        end
        check(cur_ovf(w) === eovf, $sformatf("%s ovf", name),
              32'(cur_ovf(w)), 32'(eovf));
    endtask

    initial begin
        logic [27:0] e0;
        logic [27:0] e1;
        logic        o0;
        logic        o1;
        int          n;
        int          idx;

        tab0.push_back('{16'd1234,  1'b0, {S1, S2, S3, S4}, 1'b0});
        tab0.push_back('{16'hFFD6,  1'b1, {SB, SM, S4, S2}, 1'b0});
        tab0.push_back('{16'd10000, 1'b0, {SM, SM, SM, SM}, 1'b1});
        tab0.push_back('{16'd9999,  1'b0, {S9, S9, S9, S9}, 1'b0});
        tab0.push_back('{16'd0,     1'b0, {SB, SB, SB, S0}, 1'b0});
        tab0.push_back('{16'd0,     1'b1, {SB, SB, SB, S0}, 1'b0});
        tab0.push_back('{16'hFC18,  1'b1, {SM, SM, SM, SM}, 1'b1});
        tab0.push_back('{16'h8000,  1'b1, {SM, SM, SM, SM}, 1'b1});
        tab0.push_back('{16'h8000,  1'b0, {SM, SM, SM, SM}, 1'b1});
        tab0.push_back('{16'hFC19,  1'b1, {SM, S9, S9, S9}, 1'b0});
        tab0.push_back('{16'hFFFF,  1'b1, {SB, SB, SM, S1}, 1'b0});
        tab0.push_back('{16'd7,     1'b0, {SB, SB, SB, S7}, 1'b0});
        tab0.push_back('{16'd100,   1'b0, {SB, S1, S0, S0}, 1'b0});
        tab1.push_back('{16'd1234,  1'b0, {S1, S2, S3, S4}, 1'b0});
        tab1.push_back('{16'd0,     1'b0, {S0, S0, S0, S0}, 1'b0});
        tab1.push_back('{16'h1FFB,  1'b1, {SM, S0, S0, S5}, 1'b0});
        tab1.push_back('{16'd8191,  1'b0, {S8, S1, S9, S1}, 1'b0});
        tab1.push_back('{16'h1000,  1'b1, {SM, SM, SM, SM}, 1'b1});
        tab1.push_back('{16'h1C18,  1'b1, {SM, SM, SM, SM}, 1'b1});

        #1;
        check(anode0 === 4'hF, "rst anode0", 32'(anode0), 32'hF);
        check(seg0 === SB, "rst seg0", 32'(seg0), 32'(SB));
        check(busy0 === 1'b0, "rst busy0", 32'(busy0), 0);
        check(ovf0 === 1'b0, "rst ovf0", 32'(ovf0), 0);
        @(negedge clk);
        reset = 1'b0;

        foreach (tab0[i]) begin
            @(negedge clk);
            num0 = tab0[i].num;
            sm0  = tab0[i].sm;
            repeat (SETTLE) @(negedge clk);
            check_disp(1'b0, tab0[i].exp, tab0[i].ovf, $sformatf("tab0[%0d]", i));
        end

        foreach (tab1[i]) begin
            @(negedge clk);
            num1 = tab1[i].num[12:0];
            sm1  = tab1[i].sm;
            repeat (SETTLE) @(negedge clk);
            check_disp(1'b1, tab1[i].exp, tab1[i].ovf, $sformatf("tab1[%0d]", i));
        end

        for (int r = 0; r < 16; r++) begin
            @(negedge clk);
            num0 = 16'($urandom);
            num1 = 13'($urandom);
            if ($urandom_range(0, 2) == 0) num0 = 16'($urandom_range(0, 300));
            if ($urandom_range(0, 2) == 0) num1 = 13'($urandom_range(0, 300));
            if ($urandom_range(0, 2) == 0) num0 = 16'hFFFF - 16'($urandom_range(0, 1200));
            sm0 = 1'($urandom_range(0, 1));
            sm1 = 1'($urandom_range(0, 1));
            repeat (SETTLE) @(negedge clk);
            model(longint'(num0), 16, sm0, 1'b1, e0, o0);
            model(longint'(num1), 13, sm1, 1'b0, e1, o1);
            check_disp(1'b0, e0, o0, $sformatf("rnd0[%0d]", r));
            check_disp(1'b1, e1, o1, $sformatf("rnd1[%0d]", r));
        end

        // Reset in the middle of a conversion with overflow showing.
        @(negedge clk);
        num0 = 16'd10000;
        sm0  = 1'b0;
        repeat (SETTLE) @(negedge clk);
        check(ovf0 === 1'b1, "pre-rst ovf0", 32'(ovf0), 1);
        n = 0;
        while (busy0 !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check(n < 40, "busy0 seen", 32'(n), 40);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check(anode0 === 4'hF, "midrst anode0", 32'(anode0), 32'hF);
        check(seg0 === SB, "midrst seg0", 32'(seg0), 32'(SB));
        check(busy0 === 1'b0, "midrst busy0", 32'(busy0), 0);
        check(ovf0 === 1'b0, "midrst ovf0", 32'(ovf0), 0);
        check(anode1 === 4'hF, "midrst anode1", 32'(anode1), 32'hF);
        check(seg1 === SB, "midrst seg1", 32'(seg1), 32'(SB));

        num0 = 16'd42;
        sm0  = 1'b0;
        num1 = 13'd1234;
        sm1  = 1'b0;
        model(longint'(num0), 16, 1'b0, 1'b1, e0, o0);
        model(longint'(num1), 13, 1'b0, 1'b0, e1, o1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            @(posedge clk);
            #1;
            idx = (k / RDIV) % 4;
            check(anode0 === ~(4'b0001 << idx), $sformatf("lat anode0 k%0d", k),
                  32'(anode0), 32'(~(4'b0001 << idx)));
            check(busy0 === (((k - 1) % 18) < 16), $sformatf("lat busy0 k%0d", k),
                  32'(busy0), 32'(((k - 1) % 18) < 16));
            check(seg0 === ((k < 18) ? SB : e0[7*idx +: 7]),
                  $sformatf("lat seg0 k%0d", k), 32'(seg0),
                  32'((k < 18) ? SB : e0[7*idx +: 7]));
            check(seg1 === ((k < 15) ? SB : e1[7*idx +: 7]),
                  $sformatf("lat seg1 k%0d", k), 32'(seg1),
                  32'((k < 15) ? SB : e1[7*idx +: 7]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
